// File: rtl/wt_cache_pkg.sv
// Shared types and helpers for the write-through cache memory arbiter.
package wt_cache_pkg;

   // Arbitration policy selector.
   typedef enum logic {
      ARB_RR    = 1'b0,
      ARB_FIXED = 1'b1
   } wt_arb_mode_e;

   // Width of the source-index field in a memory tag (at least one bit).
   function automatic int unsigned idx_width(input int unsigned num_req);
      return (num_req <= 1) ? 1 : $clog2(num_req);
   endfunction

endpackage

// File: rtl/wt_mem_arb_rr.sv
// Grant selector: round-robin from a rotating pointer, or lowest-index-first.
module wt_mem_arb_rr
   import wt_cache_pkg::*;
#(
   parameter int unsigned  NumReq = 2,
   parameter int unsigned  IdxW   = 1,
   parameter wt_arb_mode_e Mode   = ARB_RR
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [NumReq-1:0] elig_i,
   output logic [NumReq-1:0] gnt_c,
   output logic [IdxW-1:0]   gnt_idx_c,
   output logic              gnt_vld_c
);

   localparam int unsigned SumW = IdxW + 1;

   logic [IdxW-1:0]     ptr_q;
   logic [IdxW-1:0]     start_c;
   logic [2*NumReq-1:0] elig_dbl_c;
   logic [NumReq-1:0]   elig_rot_c;
   logic [IdxW-1:0]     first_c;
   logic [SumW-1:0]     sum_c;

   // Rotate eligibility so the search origin sits at bit 0, then find the first set bit.
   always_comb begin
      start_c    = (Mode == ARB_FIXED) ? '0 : ptr_q;
      elig_dbl_c = {elig_i, elig_i};
      elig_rot_c = elig_dbl_c[start_c +: NumReq];
      first_c    = '0;
      for (int i = int'(NumReq) - 1; i >= 0; i--) begin
         if (elig_rot_c[i]) first_c = IdxW'(i);
      end
      sum_c = {1'b0, start_c} + {1'b0, first_c};
      if (sum_c >= SumW'(NumReq)) sum_c = sum_c - SumW'(NumReq);
      gnt_vld_c = |elig_i;
      gnt_idx_c = IdxW'(sum_c);
      gnt_c     = '0;
      for (int i = 0; i < int'(NumReq); i++) begin
         gnt_c[i] = gnt_vld_c && (gnt_idx_c == IdxW'(i));
      end
   end

   // Pointer moves just past the winner; it holds when nothing is granted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= '0;
      end else if (gnt_vld_c) begin
         ptr_q <= (gnt_idx_c == IdxW'(NumReq - 1)) ? '0 : gnt_idx_c + IdxW'(1);
      end
   end

endmodule

// File: rtl/wt_mem_arb.sv
// Merges N cache memory channels onto one adapter port, tags by source, routes returns back.
module wt_mem_arb
   import wt_cache_pkg::*;
#(
   parameter int unsigned NumReq         = 2,
   parameter int unsigned ReqWidth       = 128,
   parameter int unsigned RtrnWidth      = 256,
   parameter int unsigned TidWidth       = 2,
   parameter int unsigned MaxOutstanding = 4,
   parameter int unsigned ArbMode        = 0
) (
   input  logic                                        clk_i,
   input  logic                                        rst_ni,
   input  logic [NumReq-1:0]                           req_vld_i,
   output logic [NumReq-1:0]                           req_ack_o,
   input  logic [NumReq*ReqWidth-1:0]                  req_data_i,
   input  logic [NumReq*TidWidth-1:0]                  req_tid_i,
   output logic                                        mem_req_o,
   input  logic                                        mem_ack_i,
   output logic [ReqWidth-1:0]                         mem_data_o,
   output logic [wt_cache_pkg::idx_width(NumReq)+TidWidth-1:0] mem_tid_o,
   input  logic                                        mem_rtrn_vld_i,
   input  logic [wt_cache_pkg::idx_width(NumReq)+TidWidth-1:0] mem_rtrn_tid_i,
   input  logic [RtrnWidth-1:0]                        mem_rtrn_data_i,
   output logic [NumReq-1:0]                           rtrn_vld_o,
   output logic [RtrnWidth-1:0]                        rtrn_data_o,
   output logic [TidWidth-1:0]                         rtrn_tid_o,
   input  logic                                        drain_i,
   output logic                                        idle_o,
   output logic                                        err_o
);

   localparam int unsigned  IdxW = idx_width(NumReq);
   localparam int unsigned  TagW = IdxW + TidWidth;
   localparam int unsigned  CntW = $clog2(MaxOutstanding + 1);
   localparam wt_arb_mode_e Mode = (ArbMode == 1) ? ARB_FIXED : ARB_RR;

   logic [CntW-1:0]      cnt_q [NumReq];
   logic                 out_full_q;
   logic [ReqWidth-1:0]  out_data_q;
   logic [TagW-1:0]      out_tag_q;
   logic [NumReq-1:0]    rtrn_vld_q;
   logic [RtrnWidth-1:0] rtrn_data_q;
   logic [TidWidth-1:0]  rtrn_tid_q;
   logic                 err_q;

   logic                 load_ok_c;
   logic [NumReq-1:0]    elig_c;
   logic [NumReq-1:0]    gnt_c;
   logic [IdxW-1:0]      gnt_idx_c;
   logic                 gnt_vld_c;
   logic [ReqWidth-1:0]  sel_data_c;
   logic [TidWidth-1:0]  sel_tid_c;
   logic [IdxW-1:0]      rtrn_idx_c;
   logic [NumReq-1:0]    rtrn_ok_c;
   logic                 rtrn_bad_c;
   logic                 cnt_zero_c;

   // Output register may refill when empty or when its current entry retires this cycle.
   assign load_ok_c = !out_full_q || mem_ack_i;

   // A requester competes only with a free in-flight slot, no drain and a loadable register.
   always_comb begin
      elig_c = '0;
      for (int i = 0; i < int'(NumReq); i++) begin
         elig_c[i] = req_vld_i[i] && (cnt_q[i] < CntW'(MaxOutstanding)) && !drain_i && load_ok_c;
      end
   end

   wt_mem_arb_rr #(
      .NumReq (NumReq),
      .IdxW   (IdxW),
      .Mode   (Mode)
   ) u_sel (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .elig_i    (elig_c),
      .gnt_c     (gnt_c),
      .gnt_idx_c (gnt_idx_c),
      .gnt_vld_c (gnt_vld_c)
   );

   // Payload and TID of the granted requester.
   always_comb begin
      sel_data_c = '0;
      sel_tid_c  = '0;
      for (int i = 0; i < int'(NumReq); i++) begin
         if (gnt_c[i]) begin
            sel_data_c = req_data_i[i*ReqWidth +: ReqWidth];
            sel_tid_c  = req_tid_i[i*TidWidth +: TidWidth];
         end
      end
   end

   // Classify a return; a slot already being delivered this cycle no longer counts as live.
   always_comb begin
      rtrn_idx_c = mem_rtrn_tid_i[TagW-1 -: IdxW];
      rtrn_ok_c  = '0;
      rtrn_bad_c = 1'b0;
      if (mem_rtrn_vld_i) begin
         rtrn_bad_c = 1'b1;
         for (int i = 0; i < int'(NumReq); i++) begin
            if ((rtrn_idx_c == IdxW'(i)) && (cnt_q[i] > CntW'(rtrn_vld_q[i]))) begin
               rtrn_ok_c[i] = 1'b1;
               rtrn_bad_c   = 1'b0;
            end
         end
      end
   end

   // In-flight counters: up on grant, down when the return is delivered upstream.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(NumReq); i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < int'(NumReq); i++) begin
            cnt_q[i] <= cnt_q[i] + CntW'(gnt_c[i]) - CntW'(rtrn_vld_q[i]);
         end
      end
   end

   // One-entry output register toward the memory adapter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_full_q <= 1'b0;
         out_data_q <= '0;
         out_tag_q  <= '0;
      end else if (gnt_vld_c) begin
         out_full_q <= 1'b1;
         out_data_q <= sel_data_c;
         out_tag_q  <= {gnt_idx_c, sel_tid_c};
      end else if (mem_ack_i) begin
         out_full_q <= 1'b0;
      end
   end

   // Return register and sticky error flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rtrn_vld_q  <= '0;
         rtrn_data_q <= '0;
         rtrn_tid_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         rtrn_vld_q <= rtrn_ok_c;
         if (|rtrn_ok_c) begin
            rtrn_data_q <= mem_rtrn_data_i;
            rtrn_tid_q  <= mem_rtrn_tid_i[TidWidth-1:0];
         end
         err_q <= err_q | rtrn_bad_c;
      end
   end

   // Idle once nothing is in flight and the output register is empty.
   always_comb begin
      cnt_zero_c = 1'b1;
      for (int i = 0; i < int'(NumReq); i++) begin
         if (cnt_q[i] != '0) cnt_zero_c = 1'b0;
      end
   end

   assign req_ack_o   = gnt_c;
   assign mem_req_o   = out_full_q;
   assign mem_data_o  = out_data_q;
   assign mem_tid_o   = out_tag_q;
   assign rtrn_vld_o  = rtrn_vld_q;
   assign rtrn_data_o = rtrn_data_q;
   assign rtrn_tid_o  = rtrn_tid_q;
   assign idle_o      = cnt_zero_c && !out_full_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_wt_mem_arb.sv
// Bench for wt_mem_arb: round-robin instance (3 req, limit 2) and fixed-priority instance (3 req, limit 4).
module tb_wt_mem_arb;

   logic        clk;
   logic        rst_n;
   logic [2:0]  vld   [2];
   logic [47:0] data  [2];
   logic [5:0]  tid   [2];
   logic        mack  [2];
   logic        rv_in [2];
   logic [3:0]  rtag  [2];
   logic [15:0] rdat  [2];
   logic        drain [2];

   logic [2:0]  ack   [2];
   logic        mreq  [2];
   logic [15:0] mdata [2];
   logic [3:0]  mtid  [2];
   logic [2:0]  rvo   [2];
   logic [15:0] rdo   [2];
   logic [1:0]  rtido [2];
   logic        idle  [2];
   logic        err   [2];

   int errors = 0;
   int checks = 0;

   wt_mem_arb #(
      .NumReq(3), .ReqWidth(16), .RtrnWidth(16), .TidWidth(2), .MaxOutstanding(2), .ArbMode(0)
   ) u_rr (
      .clk_i(clk), .rst_ni(rst_n),
      .req_vld_i(vld[0]), .req_ack_o(ack[0]), .req_data_i(data[0]), .req_tid_i(tid[0]),
      .mem_req_o(mreq[0]), .mem_ack_i(mack[0]), .mem_data_o(mdata[0]), .mem_tid_o(mtid[0]),
      .mem_rtrn_vld_i(rv_in[0]), .mem_rtrn_tid_i(rtag[0]), .mem_rtrn_data_i(rdat[0]),
      .rtrn_vld_o(rvo[0]), .rtrn_data_o(rdo[0]), .rtrn_tid_o(rtido[0]),
      .drain_i(drain[0]), .idle_o(idle[0]), .err_o(err[0])
   );

   wt_mem_arb #(
      .NumReq(3), .ReqWidth(16), .RtrnWidth(16), .TidWidth(2), .MaxOutstanding(4), .ArbMode(1)
   ) u_fx (
      .clk_i(clk), .rst_ni(rst_n),
      .req_vld_i(vld[1]), .req_ack_o(ack[1]), .req_data_i(data[1]), .req_tid_i(tid[1]),
      .mem_req_o(mreq[1]), .mem_ack_i(mack[1]), .mem_data_o(mdata[1]), .mem_tid_o(mtid[1]),
      .mem_rtrn_vld_i(rv_in[1]), .mem_rtrn_tid_i(rtag[1]), .mem_rtrn_data_i(rdat[1]),
      .rtrn_vld_o(rvo[1]), .rtrn_data_o(rdo[1]), .rtrn_tid_o(rtido[1]),
      .drain_i(drain[1]), .idle_o(idle[1]), .err_o(err[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: per-requester live transactions, delivery flags, output slot.
   int          live [2][3];
   bit          dlv  [2][3];
   int          ptr  [2];
   bit          full [2];
   logic [15:0] od   [2];
   logic [3:0]  ot   [2];
   logic [15:0] erd  [2];
   logic [1:0]  ert  [2];
   bit          eerr [2];

   always @(negedge clk) begin : cmp
      int       mx;
      int       w;
      int       cand;
      int       k;
      bit       eidle;
      logic [2:0] eack;
      logic [2:0] erv;
      for (int n = 0; n < 2; n++) begin
         if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
               live[n][i] = 0;
               dlv[n][i]  = 0;
            end
            ptr[n] = 0; full[n] = 0; od[n] = '0; ot[n] = '0;
            erd[n] = '0; ert[n] = '0; eerr[n] = 0;
            chk($sformatf("u%0d_rst_ack", n),   32'(ack[n]),   0);
            chk($sformatf("u%0d_rst_mreq", n),  32'(mreq[n]),  0);
            chk($sformatf("u%0d_rst_mdata", n), 32'(mdata[n]), 0);
            chk($sformatf("u%0d_rst_mtid", n),  32'(mtid[n]),  0);
            chk($sformatf("u%0d_rst_rvo", n),   32'(rvo[n]),   0);
            chk($sformatf("u%0d_rst_idle", n),  32'(idle[n]),  1);
            chk($sformatf("u%0d_rst_err", n),   32'(err[n]),   0);
         end else begin
            mx = (n == 0) ? 2 : 4;
            w  = -1;
            if (!full[n] || mack[n]) begin
               for (int o = 0; o < 3; o++) begin
                  cand = (n == 1) ? o : (ptr[n] + o) % 3;
                  if (w < 0 && vld[n][cand] && !drain[n] && (live[n][cand] + int'(dlv[n][cand])) < mx)
                     w = cand;
               end
            end
            eack  = (w >= 0) ? 3'(1 << w) : 3'b000;
            erv   = {dlv[n][2], dlv[n][1], dlv[n][0]};
            eidle = !full[n];
            for (int i = 0; i < 3; i++) if (live[n][i] + int'(dlv[n][i]) != 0) eidle = 0;

            chk($sformatf("u%0d_ack", n),  32'(ack[n]),  32'(eack));
            chk($sformatf("u%0d_mreq", n), 32'(mreq[n]), 32'(full[n]));
            if (full[n]) begin
               chk($sformatf("u%0d_mdata", n), 32'(mdata[n]), 32'(od[n]));
               chk($sformatf("u%0d_mtid", n),  32'(mtid[n]),  32'(ot[n]));
            end
            chk($sformatf("u%0d_rvo", n), 32'(rvo[n]), 32'(erv));
            if (erv != 0) begin
               chk($sformatf("u%0d_rdata", n), 32'(rdo[n]),   32'(erd[n]));
               chk($sformatf("u%0d_rtid", n),  32'(rtido[n]), 32'(ert[n]));
            end
            chk($sformatf("u%0d_idle", n), 32'(idle[n]), 32'(eidle));
            chk($sformatf("u%0d_err", n),  32'(err[n]),  32'(eerr[n]));

            // advance to the next cycle
            if (full[n] && mack[n]) full[n] = 0;
            for (int i = 0; i < 3; i++) dlv[n][i] = 0;
            if (rv_in[n]) begin
               k = int'(rtag[n][3:2]);
               if (k < 3 && live[n][k] > 0) begin
                  live[n][k]--;
                  dlv[n][k] = 1;
                  erd[n] = rdat[n];
                  ert[n] = rtag[n][1:0];
               end else begin
                  eerr[n] = 1;
               end
            end
            if (w >= 0) begin
               full[n] = 1;
               od[n]   = data[n][w*16 +: 16];
               ot[n]   = {2'(w), tid[n][w*2 +: 2]};
               live[n][w]++;
               ptr[n]  = (w + 1) % 3;
            end
         end
      end
   end

   // Directed stimulus with hand-computed literal expectations.
   initial begin
      logic [3:0] dtags [6];
      dtags[0] = 4'b0000; dtags[1] = 4'b0001; dtags[2] = 4'b0100;
      dtags[3] = 4'b0101; dtags[4] = 4'b1000; dtags[5] = 4'b1001;
      rst_n = 1'b0;
      for (int n = 0; n < 2; n++) begin
         vld[n] = '0; mack[n] = 1'b0; rv_in[n] = 1'b0; rtag[n] = '0;
         rdat[n] = '0; drain[n] = 1'b0;
      end
      data[0] = {16'hC2C2, 16'hB1B1, 16'hA0A0};
      tid[0]  = {2'd2, 2'd1, 2'd3};
      data[1] = {16'h2222, 16'h1111, 16'h0F0F};
      tid[1]  = {2'd1, 2'd0, 2'd2};

      tick();
      @(negedge clk);
      chk("reset_idle", 32'(idle[0]), 1);
      chk("reset_mreq", 32'(mreq[0]), 0);
      tick();
      rst_n = 1'b1;

      // round-robin fairness, each requester reaches its limit of 2
      vld[0] = 3'b111; mack[0] = 1'b1;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         chk("rr_order", 32'(ack[0]), (c < 6) ? (1 << (c % 3)) : 0);
         if (c >= 1) chk("rr_tag_idx", 32'(mtid[0][3:2]), (c - 1) % 3);
         tick();
      end

      // one return to requester 0 frees one slot, visible the cycle after delivery
      mack[0] = 1'b0; rv_in[0] = 1'b1; rtag[0] = 4'b0001; rdat[0] = 16'h5A5A;
      @(negedge clk);
      chk("limit_stall", 32'(ack[0]), 0);
      tick();
      rv_in[0] = 1'b0;
      @(negedge clk);
      chk("rtrn_vld", 32'(rvo[0]), 32'b001);
      chk("rtrn_data", 32'(rdo[0]), 32'h5A5A);
      chk("rtrn_tid", 32'(rtido[0]), 1);
      chk("limit_no_ack_yet", 32'(ack[0]), 0);
      tick();
      @(negedge clk);
      chk("limit_third_ack", 32'(ack[0]), 32'b001);
      tick();

      // back-pressure: entry held, no new grants
      rv_in[0] = 1'b1; rtag[0] = 4'b0110; rdat[0] = 16'h6B6B;
      for (int b = 0; b < 5; b++) begin
         @(negedge clk);
         chk("bp_mreq", 32'(mreq[0]), 1);
         chk("bp_mdata", 32'(mdata[0]), 32'hA0A0);
         chk("bp_mtid", 32'(mtid[0]), 32'b0011);
         chk("bp_no_ack", 32'(ack[0]), 0);
         tick();
         rv_in[0] = 1'b0;
      end
      mack[0] = 1'b1;
      @(negedge clk);
      chk("bp_release_ack", 32'(ack[0]), 32'b010);
      tick();

      // drain: no new grants, idle after the last return is delivered
      drain[0] = 1'b1;
      for (int d = 0; d < 3; d++) begin
         @(negedge clk);
         chk("drain_no_ack", 32'(ack[0]), 0);
         tick();
      end
      for (int j = 0; j < 6; j++) begin
         rv_in[0] = 1'b1; rtag[0] = dtags[j]; rdat[0] = 16'(16'h1000 + j);
         @(negedge clk);
         chk("drain_busy", 32'(idle[0]), 0);
         tick();
      end
      rv_in[0] = 1'b0;
      @(negedge clk);
      chk("drain_last_rtrn", 32'(rvo[0]), 32'b100);
      chk("drain_not_idle", 32'(idle[0]), 0);
      tick();
      @(negedge clk);
      chk("drain_idle", 32'(idle[0]), 1);
      tick();
      drain[0] = 1'b0; vld[0] = '0;

      // out-of-range return index
      rv_in[0] = 1'b1; rtag[0] = 4'b1100;
      @(negedge clk);
      chk("err_before", 32'(err[0]), 0);
      tick();
      rv_in[0] = 1'b0;
      @(negedge clk);
      chk("err_set", 32'(err[0]), 1);
      chk("err_no_rtrn", 32'(rvo[0]), 0);
      repeat (3) tick();
      @(negedge clk);
      chk("err_sticky", 32'(err[0]), 1);
      tick();

      // fixed priority: requester 0 wins until its limit of 4
      vld[1] = 3'b101; mack[1] = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("fx_prio", 32'(ack[1]), 32'b001);
         tick();
      end
      @(negedge clk);
      chk("fx_after_limit", 32'(ack[1]), 32'b100);
      tick();
      vld[1] = '0;

      // reset in the middle of a burst, then a late return
      vld[0] = 3'b111; mack[0] = 1'b1;
      repeat (2) tick();
      rst_n = 1'b0; vld[0] = '0;
      @(negedge clk);
      chk("mid_rst_mreq", 32'(mreq[0]), 0);
      chk("mid_rst_idle", 32'(idle[0]), 1);
      chk("mid_rst_err", 32'(err[0]), 0);
      tick();
      rst_n = 1'b1;
      rv_in[0] = 1'b1; rtag[0] = 4'b0000;
      tick();
      rv_in[0] = 1'b0;
      @(negedge clk);
      chk("late_rtrn_err", 32'(err[0]), 1);
      chk("late_rtrn_drop", 32'(rvo[0]), 0);
      repeat (2) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
